// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   state_e          : arbiter FSM states
//   OWN_CORE/OWN_HOST: encoding of the owner output
//   ADDR_W_DEF/DATA_W_DEF : default bus widths
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_HOST = 1'b1;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Host starvation counter for dmem_arbiter (built only with
// DMEM_ARB_STARVE_GUARD_EN).
//   clk, rst   : clock, async active-low reset
//   arb        : an IDLE arbitration is taking place this cycle
//   host_req   : host is requesting
//   host_win   : host wins this arbitration
//   force_host : host has lost STARVE_MAX times; it wins the next arbitration
module dmem_arb_starve_ctr #(
  parameter int STARVE_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic arb,
  input  logic host_req,
  input  logic host_win,
  output logic force_host
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt;

  // Saturates at STARVE_MAX; a host grant always clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  cnt <= '0;
    else if (arb && host_win)                  cnt <= '0;
    else if (arb && host_req && !force_host)   cnt <= cnt + 1'b1;
  end

  assign force_host = (cnt == CW'(STARVE_MAX));

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port, word-addressed data memory
// (one-cycle synchronous read). Core has fixed priority; the host/debug port
// gets the memory when the core is idle. Each access takes IDLE -> GRANT ->
// RESP; the requester's ack pulses in RESP with read data alongside.
// Optional: DMEM_ARB_STARVE_GUARD_EN enables a host starvation guard.
//   clk, rst                  : clock, async active-low reset
//   core_req/we/addr/wdata    : core request (held until core_ack)
//   core_ack/rdata/stall      : core completion, read data, stall
//   host_req/we/addr/wdata    : host request (held until host_ack)
//   host_ack/rdata            : host completion, read data
//   mem_addr/we/wdata, mem_rdata : memory port
//   busy, owner               : FSM not idle; last grant (0 core, 1 host)
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_ack,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  state_e            state, state_nxt;
  logic              owner_nxt;
  logic              arb, host_win, force_host;
  logic [DATA_W-1:0] core_rdata_q, host_rdata_q;

  assign arb = (state == IDLE) && (core_req || host_req);

`ifdef DMEM_ARB_STARVE_GUARD_EN
  dmem_arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk       (clk),
    .rst       (rst),
    .arb       (arb),
    .host_req  (host_req),
    .host_win  (host_win),
    .force_host(force_host)
  );
`else
  localparam int unused_starve_max = STARVE_MAX;
  assign force_host = 1'b0;
`endif

  assign host_win = host_req && (!core_req || force_host);

  // FSM next state / owner
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    case (state)
      IDLE:  if (arb) begin
               state_nxt = GRANT;
               owner_nxt = host_win ? OWN_HOST : OWN_CORE;
             end
      GRANT: state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      owner <= OWN_CORE;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  // Memory port is loaded at the arbitration edge so it is stable through
  // GRANT; address/data then hold, the write strobe lasts only GRANT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else if (arb) begin
      mem_addr  <= host_win ? host_addr  : core_addr;
      mem_wdata <= host_win ? host_wdata : core_wdata;
      mem_we    <= host_win ? host_we    : core_we;
    end else begin
      mem_we    <= 1'b0;
    end
  end

  // Read data is valid in RESP straight from memory; the register keeps it
  // afterwards until the same requester's next ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_rdata_q <= '0;
      host_rdata_q <= '0;
    end else if (state == RESP) begin
      if (owner == OWN_HOST) host_rdata_q <= mem_rdata;
      else                   core_rdata_q <= mem_rdata;
    end
  end

  assign core_ack   = (state == RESP) && (owner == OWN_CORE);
  assign host_ack   = (state == RESP) && (owner == OWN_HOST);
  assign core_rdata = core_ack ? mem_rdata : core_rdata_q;
  assign host_rdata = host_ack ? mem_rdata : host_rdata_q;
  assign core_stall = core_req && !core_ack;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// traffic, all compared against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          core_req = 0, core_we = 0, host_req = 0, host_we = 0;
  logic [AW-1:0] core_addr = '0, host_addr = '0;
  logic [DW-1:0] core_wdata = '0, host_wdata = '0;
  logic          core_ack, core_stall, host_ack, mem_we, busy, owner;
  logic [DW-1:0] core_rdata, host_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_ack(core_ack), .core_rdata(core_rdata),
    .core_stall(core_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  // Single-port synchronous memory, read-before-write, 16 words used.
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[3:0]];
  end

  int vecs = 0, errs = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [DW-1:0] ref_mem [16];
  int            cyc, g;           // cycle index, cycle of last grant
  logic          g_own, g_we;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata, g_rd;
  logic          exp_owner;
  logic [DW-1:0] exp_crd, exp_hrd;
  int            starve;
  // observations
  logic          saw_cack, saw_hack;
  logic [DW-1:0] ack_crd, ack_hrd;
  int            cack_cyc, hack_cyc, we_cnt, stall_cnt;

  task automatic model_reset();
    cyc = 0; g = -10; exp_owner = 0; exp_crd = '0; exp_hrd = '0; starve = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic set_in(input logic cr, cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                        input logic hr, hw, input logic [AW-1:0] ha, input logic [DW-1:0] hd);
    core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
  endtask

  // Compare this cycle's outputs against the model, then let the model
  // observe this cycle's requests.
  task automatic sample();
    logic eca, eha, win, frc;
    @(negedge clk);
    eca = (g >= 0) && (cyc == g + 2) && (g_own == 1'b0);
    eha = (g >= 0) && (cyc == g + 2) && (g_own == 1'b1);
    if (eca) exp_crd = g_rd;
    if (eha) exp_hrd = g_rd;
    chk("core_ack",   core_ack, eca);
    chk("host_ack",   host_ack, eha);
    chk("core_rdata", core_rdata, exp_crd);
    chk("host_rdata", host_rdata, exp_hrd);
    chk("core_stall", core_stall, core_req && !eca);
    chk("busy",       busy, (g >= 0) && (cyc == g + 1 || cyc == g + 2));
    chk("owner",      owner, exp_owner);
    chk("mem_we",     mem_we, (g >= 0) && (cyc == g + 1) && g_we);
    if (g >= 0 && cyc == g + 1) begin
      chk("mem_addr", mem_addr, g_addr);
      if (g_we) begin
        chk("mem_wdata", mem_wdata, g_wdata);
        ref_mem[g_addr[3:0]] = g_wdata;
      end
    end
    saw_cack = core_ack; saw_hack = host_ack;
    if (core_ack) begin ack_crd = core_rdata; cack_cyc = cyc; end
    if (host_ack) begin ack_hrd = host_rdata; hack_cyc = cyc; end
    if (mem_we) we_cnt++;
    if (core_stall) stall_cnt++;
    // arbitration: memory is free every third cycle after a grant
    if ((g < 0 || cyc >= g + 3) && (core_req || host_req)) begin
`ifdef DMEM_ARB_STARVE_GUARD_EN
      frc = (starve >= SMAX);
`else
      frc = 1'b0;
`endif
      win = host_req && (!core_req || frc);
      if (win) starve = 0;
      else if (host_req && starve < SMAX) starve++;
      g = cyc; g_own = win; exp_owner = win;
      g_we    = win ? host_we    : core_we;
      g_addr  = win ? host_addr  : core_addr;
      g_wdata = win ? host_wdata : core_wdata;
      g_rd    = ref_mem[g_addr[3:0]];
    end
    cyc++;
  endtask

  task automatic run_txn(input logic who, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      next_cycle();
      if (who) set_in(0, 0, '0, '0, 1, we, a, d);
      else     set_in(1, we, a, d, 0, 0, '0, '0);
      sample();
      done = who ? saw_hack : saw_cack;
    end
    chk("txn_done", done, 1'b1);
    next_cycle();
    set_in(0, 0, '0, '0, 0, 0, '0, '0);
    sample();
  endtask

  int start;
  logic cdone, hdone, own1, own4;
  logic [DW-1:0] old7;
  logic ca, ha, cw, hw;
  logic [AW-1:0] cad, had;
  logic [DW-1:0] cwd, hwd;

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i] = 32'h1111_0000 + 32'(i);
      ref_mem[i] = 32'h1111_0000 + 32'(i);
    end
    mem[5] = 32'hDEAD_BEEF; ref_mem[5] = 32'hDEAD_BEEF;
    model_reset();

    // reset state
    #12;
    chk("rst_busy", busy, 0);      chk("rst_owner", owner, 0);
    chk("rst_we", mem_we, 0);      chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_cack", core_ack, 0);  chk("rst_hack", host_ack, 0);
    chk("rst_crd", core_rdata, 0); chk("rst_hrd", host_rdata, 0);
    @(negedge clk); rst = 1'b1;

    // core read alone
    stall_cnt = 0; start = cyc;
    run_txn(0, 0, 5, '0);
    chk("t1_ack_lat", cack_cyc - start, 2);
    chk("t1_rdata", ack_crd, 32'hDEAD_BEEF);
    chk("t1_stall", stall_cnt, 2);

    // host write then core read
    we_cnt = 0;
    run_txn(1, 1, 3, 32'h1234_5678);
    run_txn(0, 0, 3, '0);
    chk("t2_we_cnt", we_cnt, 1);
    chk("t2_rdata", ack_crd, 32'h1234_5678);

    // simultaneous requests
    start = cyc; cdone = 0; hdone = 0; own1 = 1'bx; own4 = 1'bx;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      set_in(!cdone, 0, 5, '0, !hdone, 0, 3, '0);
      if (i == 1) own1 = owner;
      if (i == 4) own4 = owner;
      sample();
      if (saw_cack) cdone = 1;
      if (saw_hack) hdone = 1;
    end
    chk("t3_core_lat", cack_cyc - start, 2);
    chk("t3_host_lat", hack_cyc - start, 5);
    chk("t3_owner_a", own1, 0);
    chk("t3_owner_b", own4, 1);

    // reset during GRANT of a host write
    old7 = ref_mem[7];
    next_cycle(); set_in(0, 0, '0, '0, 1, 1, 7, 32'hCAFE_F00D); sample();
    next_cycle();
    chk("t5_we_pre", mem_we, 1);
    rst = 1'b0; #1;
    chk("t5_we", mem_we, 0);    chk("t5_busy", busy, 0);
    chk("t5_hack", host_ack, 0); chk("t5_owner", owner, 0);
    set_in(0, 0, '0, '0, 0, 0, '0, '0);
    @(negedge clk); @(negedge clk); rst = 1'b1;
    model_reset();
    run_txn(0, 0, 7, '0);
    chk("t5_old", ack_crd, old7);

    // starvation: core requests continuously, host held
    start = cyc; hdone = 0; hack_cyc = -1;
    for (int i = 0; i < 52; i++) begin
      next_cycle();
      set_in(i < 45, 0, 1, '0, !hdone, 0, 2, '0);
      sample();
      if (saw_hack) hdone = 1;
    end
`ifdef DMEM_ARB_STARVE_GUARD_EN
    chk("t6_host_lat", hack_cyc - start, 26);
`else
    chk("t6_host_lat", hack_cyc - start, 47);
`endif

    // randomized traffic
    ca = 0; ha = 0; cw = 0; hw = 0; cad = '0; had = '0; cwd = '0; hwd = '0;
    for (int i = 0; i < 1500; i++) begin
      next_cycle();
      if (!ca && $urandom_range(0, 1) == 1) begin
        ca = 1; cw = 1'($urandom_range(0, 1)); cad = AW'($urandom_range(0, 15)); cwd = $urandom;
      end
      if (!ha && $urandom_range(0, 2) == 0) begin
        ha = 1; hw = 1'($urandom_range(0, 1)); had = AW'($urandom_range(0, 15)); hwd = $urandom;
      end
      set_in(ca, cw, cad, cwd, ha, hw, had, hwd);
      sample();
      if (saw_cack) ca = 0;
      if (saw_hack) ha = 0;
    end
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      set_in(ca, cw, cad, cwd, ha, hw, had, hwd);
      sample();
      if (saw_cack) ca = 0;
      if (saw_hack) ha = 0;
    end
    chk("drain", {ca, ha}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
